// File: rtl/exp_final_stage_if.sv
// exp_final_stage_if
//   Bundles the handshake, data and status signals of the exponent final
//   stage. The stage itself connects through the slave modport; the
//   producer/consumer side (or a bench) uses the master modport.
//
//   Input beat : in_valid, in_ready, CONT[2:0], E_PRE_C[11:0], RND_CARRY[1:0]
//   Output beat: out_valid, out_ready, E_OUT[11:0], CONT_OUT[2:0], OVF[1:0], UNF[1:0]
//   Status     : cnt_clr, OVF_CNT[CNT_W-1:0], UNF_CNT[CNT_W-1:0]
interface exp_final_stage_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       CONT;
    logic [11:0]      E_PRE_C;
    logic [1:0]       RND_CARRY;
    logic             out_valid;
    logic             out_ready;
    logic [11:0]      E_OUT;
    logic [2:0]       CONT_OUT;
    logic [1:0]       OVF;
    logic [1:0]       UNF;
    logic             cnt_clr;
    logic [CNT_W-1:0] OVF_CNT;
    logic [CNT_W-1:0] UNF_CNT;

    modport master (
        output in_valid, CONT, E_PRE_C, RND_CARRY, out_ready, cnt_clr,
        input  in_ready, out_valid, E_OUT, CONT_OUT, OVF, UNF, OVF_CNT, UNF_CNT
    );

    modport slave (
        input  in_valid, CONT, E_PRE_C, RND_CARRY, out_ready, cnt_clr,
        output in_ready, out_valid, E_OUT, CONT_OUT, OVF, UNF, OVF_CNT, UNF_CNT
    );
endinterface

// File: rtl/exp_final_stage.sv
// exp_final_stage
//   Adds the mantissa-rounding carry to the pre-computed exponent, detects
//   per-lane overflow/underflow and saturates to the infinity (EMAX+1) or
//   zero code. Mode 1/3 use one 12-bit lane, mode 2 uses two independent
//   6-bit lanes. Results leave through a 2-stage elastic valid/ready pipe;
//   saturating event counters track accepted beats carrying OVF/UNF.
//
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : exp_final_stage_if.slave (input beat, output beat, counters)
module exp_final_stage #(
    parameter int EMAX1 = 2046,
    parameter int EMAX2 = 30,
    parameter int EMAX3 = 254,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    exp_final_stage_if.slave     bus
);

    localparam logic signed [12:0] EMAX1_S = 13'(EMAX1);
    localparam logic signed [12:0] EMAX3_S = 13'(EMAX3);
    localparam logic signed [6:0]  EMAX2_S = 7'(EMAX2);
    localparam logic [11:0]        INF1    = 12'(EMAX1 + 1);
    localparam logic [11:0]        INF3    = 12'(EMAX3 + 1);
    localparam logic [5:0]         INF2    = 6'(EMAX2 + 1);

    // Result packed as {ovf, unf, exponent}.
    function automatic logic [13:0] sat_wide(input logic signed [12:0] s,
                                             input logic signed [12:0] emax,
                                             input logic [11:0]        inf);
        logic [13:0] r;
        if (s > emax)
            r = {2'b10, inf};
        else if (s < 13'sd1)
            r = {2'b01, 12'd0};
        else
            r = {2'b00, s[11:0]};
        return r;
    endfunction

    function automatic logic [7:0] sat_lane(input logic signed [6:0] s);
        logic [7:0] r;
        if (s > EMAX2_S)
            r = {2'b10, INF2};
        else if (s < 7'sd1)
            r = {2'b01, 6'd0};
        else
            r = {2'b00, s[5:0]};
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic              vld_p1, vld_p2;
    logic [2:0]        cont_p1, cont_p2;
    logic [11:0]       e_pre_p1;
    logic [1:0]        carry_p1;
    logic [11:0]       e_out_p2;
    logic [1:0]        ovf_p2, unf_p2;
    logic [CNT_W-1:0]  ovf_cnt, unf_cnt;

    logic              s2_adv, s1_adv, in_ready_c, out_acc;
    logic signed [12:0] sum_w;
    logic signed [6:0]  sum_hi, sum_lo;
    logic [13:0]       res_w;
    logic [7:0]        res_hi, res_lo;
    logic [11:0]       e_nxt;
    logic [1:0]        ovf_nxt, unf_nxt;

    assign s2_adv     = !vld_p2 || bus.out_ready;
    assign s1_adv     = vld_p1 && s2_adv;
    // Combinational from out_ready so a full pipe keeps streaming.
    assign in_ready_c = !vld_p1 || s2_adv;
    assign out_acc    = vld_p2 && bus.out_ready;

    always_comb begin
        sum_w  = $signed({e_pre_p1[11], e_pre_p1}) + $signed({12'd0, carry_p1[0]});
        sum_hi = $signed({e_pre_p1[11], e_pre_p1[11:6]}) + $signed({6'd0, carry_p1[1]});
        sum_lo = $signed({e_pre_p1[5], e_pre_p1[5:0]}) + $signed({6'd0, carry_p1[0]});
        res_w  = sat_wide(sum_w, cont_p1[1] ? EMAX3_S : EMAX1_S, cont_p1[1] ? INF3 : INF1);
        res_hi = sat_lane(sum_hi);
        res_lo = sat_lane(sum_lo);
        // CONT[1] selects mode 3; otherwise CONT[0] picks mode 2 over mode 1.
        if (!cont_p1[1] && cont_p1[0]) begin
            e_nxt   = {res_hi[5:0], res_lo[5:0]};
            ovf_nxt = {res_hi[7], res_lo[7]};
            unf_nxt = {res_hi[6], res_lo[6]};
        end else begin
            e_nxt   = res_w[11:0];
            ovf_nxt = {1'b0, res_w[13]};
            unf_nxt = {1'b0, res_w[12]};
        end
    end

    // S1: input capture
    always_ff @(posedge clk) begin
        if (in_ready_c && bus.in_valid) begin
            cont_p1  <= bus.CONT;
            e_pre_p1 <= bus.E_PRE_C;
            carry_p1 <= bus.RND_CARRY;
        end
    end

    // S2: saturated result, control and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            e_out_p2 <= '0;
            cont_p2  <= '0;
            ovf_p2   <= '0;
            unf_p2   <= '0;
            ovf_cnt  <= '0;
            unf_cnt  <= '0;
        end else begin
            if (in_ready_c)
                vld_p1 <= bus.in_valid;
            if (s2_adv)
                vld_p2 <= vld_p1;
            if (s1_adv) begin
                e_out_p2 <= e_nxt;
                cont_p2  <= cont_p1;
                ovf_p2   <= ovf_nxt;
                unf_p2   <= unf_nxt;
            end
            if (bus.cnt_clr) begin
                ovf_cnt <= '0;
                unf_cnt <= '0;
            end else begin
                if (out_acc && |ovf_p2)
                    ovf_cnt <= sat_inc(ovf_cnt);
                if (out_acc && |unf_p2)
                    unf_cnt <= sat_inc(unf_cnt);
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = vld_p2;
    assign bus.E_OUT     = e_out_p2;
    assign bus.CONT_OUT  = cont_p2;
    assign bus.OVF       = ovf_p2;
    assign bus.UNF       = unf_p2;
    assign bus.OVF_CNT   = ovf_cnt;
    assign bus.UNF_CNT   = unf_cnt;

endmodule

// File: tb/tb_exp_final_stage.sv
module tb_exp_final_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exp_final_stage_if #(.CNT_W(8)) ifc ();

    exp_final_stage #(.EMAX1(2046), .EMAX2(30), .EMAX3(254), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    typedef struct packed {
        logic [11:0] e;
        logic [2:0]  c;
        logic [1:0]  o;
        logic [1:0]  u;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: samples shortly before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst && ifc.out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_beat: got E_OUT=%0h with no beat expected", ifc.E_OUT);
                end else begin
                    checks++;
                    if ({ifc.E_OUT, ifc.CONT_OUT, ifc.OVF, ifc.UNF} !== q[0]) begin
                        errors++;
                        $display("FAIL %s: got E=%0h C=%0b O=%0b U=%0b expected E=%0h C=%0b O=%0b U=%0b",
                                 ifc.out_ready ? "beat" : "stall_hold",
                                 ifc.E_OUT, ifc.CONT_OUT, ifc.OVF, ifc.UNF,
                                 q[0].e, q[0].c, q[0].o, q[0].u);
                    end
                    if (ifc.out_ready)
                        void'(q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [2:0] c, input logic [11:0] e, input logic [1:0] rc,
                        input logic [11:0] xe, input logic [1:0] xo, input logic [1:0] xu);
        bit acc;
        int tries;
        exp_t x;
        acc = 0;
        tries = 0;
        @(negedge clk);
        ifc.in_valid  = 1'b1;
        ifc.CONT      = c;
        ifc.E_PRE_C   = e;
        ifc.RND_CARRY = rc;
        forever begin
            #4;
            acc = ifc.in_ready;
            @(posedge clk);
            if (acc) break;
            tries++;
            if (tries > 200) break;
            @(negedge clk);
        end
        if (acc) begin
            x.e = xe; x.c = c; x.o = xo; x.u = xu;
            q.push_back(x);
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for 200 cycles expected acceptance");
        end
        #1 ifc.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", q.size(), 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.CONT      = 3'b000;
        ifc.E_PRE_C   = 12'd0;
        ifc.RND_CARRY = 2'b00;
        ifc.out_ready = 1'b1;
        ifc.cnt_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_in_ready", ifc.in_ready, 1);
        chk("rst_e_out", ifc.E_OUT, 0);
        chk("rst_cont_out", ifc.CONT_OUT, 0);
        chk("rst_flags", {ifc.OVF, ifc.UNF}, 0);
        chk("rst_ovf_cnt", ifc.OVF_CNT, 0);
        chk("rst_unf_cnt", ifc.UNF_CNT, 0);

        // Latency: out_valid appears two cycles after the accepting cycle.
        send(3'b000, 12'd100, 2'b00, 12'd100, 2'b00, 2'b00);
        @(negedge clk);
        chk("lat_cycle1", ifc.out_valid, 0);
        @(negedge clk);
        chk("lat_cycle2", ifc.out_valid, 1);
        drain();

        // Mode 1 boundaries
        send(3'b000, 12'd2046, 2'b01, 12'd2047, 2'b01, 2'b00);
        send(3'b000, 12'hFFF,  2'b01, 12'd0,    2'b00, 2'b01);
        send(3'b000, 12'd2047, 2'b00, 12'd2047, 2'b01, 2'b00);
        send(3'b000, 12'h800,  2'b11, 12'd0,    2'b00, 2'b01);
        send(3'b000, 12'd1,    2'b00, 12'd1,    2'b00, 2'b00);
        drain();
        chk("m1_ovf_cnt", ifc.OVF_CNT, 2);
        chk("m1_unf_cnt", ifc.UNF_CNT, 2);

        // Mode 2 per-lane saturation
        send(3'b001, {6'd30, 6'd5},  2'b11, {6'd31, 6'd6},  2'b10, 2'b00);
        send(3'b001, {6'h3E, 6'd30}, 2'b00, {6'd0, 6'd30},  2'b00, 2'b10);
        send(3'b001, {6'd1, 6'h3F},  2'b01, {6'd1, 6'd0},   2'b00, 2'b01);
        send(3'b001, {6'd31, 6'd31}, 2'b01, {6'd31, 6'd31}, 2'b11, 2'b00);
        send(3'b101, {6'd10, 6'd20}, 2'b10, {6'd11, 6'd20}, 2'b00, 2'b00);
        drain();
        chk("m2_ovf_cnt", ifc.OVF_CNT, 4);
        chk("m2_unf_cnt", ifc.UNF_CNT, 4);

        // Mode 3 boundaries, CONT[2] passthrough, RND_CARRY[1] ignored
        send(3'b010, 12'd254, 2'b01, 12'd255, 2'b01, 2'b00);
        send(3'b110, 12'd254, 2'b00, 12'd254, 2'b00, 2'b00);
        send(3'b010, 12'd300, 2'b00, 12'd255, 2'b01, 2'b00);
        send(3'b011, 12'd0,   2'b00, 12'd0,   2'b00, 2'b01);
        send(3'b010, 12'd5,   2'b10, 12'd5,   2'b00, 2'b00);
        drain();
        chk("m3_ovf_cnt", ifc.OVF_CNT, 6);
        chk("m3_unf_cnt", ifc.UNF_CNT, 5);

        // Backpressure mid-stream
        fork
            begin
                send(3'b000, 12'd10, 2'b00, 12'd10, 2'b00, 2'b00);
                send(3'b000, 12'd20, 2'b01, 12'd21, 2'b00, 2'b00);
                send(3'b000, 12'd30, 2'b00, 12'd30, 2'b00, 2'b00);
                send(3'b000, 12'd40, 2'b01, 12'd41, 2'b00, 2'b00);
            end
            begin
                repeat (3) @(negedge clk);
                ifc.out_ready = 1'b0;
                #2;
                chk("bp_in_ready_low", ifc.in_ready, 0);
                chk("bp_out_valid", ifc.out_valid, 1);
                repeat (3) @(negedge clk);
                ifc.out_ready = 1'b1;
            end
        join
        drain();

        // Counter saturation
        for (int i = 0; i < 300; i++)
            send(3'b000, 12'd2047, 2'b00, 12'd2047, 2'b01, 2'b00);
        drain();
        chk("sat_ovf_cnt", ifc.OVF_CNT, 255);
        chk("sat_unf_cnt", ifc.UNF_CNT, 5);

        // cnt_clr coinciding with an overflow acceptance
        ifc.out_ready = 1'b0;
        send(3'b000, 12'd2047, 2'b01, 12'd2047, 2'b01, 2'b00);
        n = 0;
        while (!ifc.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("clr_wait_valid", ifc.out_valid, 1);
        ifc.cnt_clr   = 1'b1;
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1 ifc.cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr_ovf_cnt", ifc.OVF_CNT, 0);
        chk("clr_unf_cnt", ifc.UNF_CNT, 0);
        send(3'b000, 12'd2047, 2'b00, 12'd2047, 2'b01, 2'b00);
        drain();
        chk("post_clr_ovf_cnt", ifc.OVF_CNT, 1);

        // Reset with beats in flight
        ifc.out_ready = 1'b0;
        send(3'b000, 12'd2047, 2'b00, 12'd2047, 2'b01, 2'b00);
        send(3'b000, 12'd7,    2'b00, 12'd7,    2'b00, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", ifc.out_valid, 0);
        chk("mid_rst_in_ready", ifc.in_ready, 1);
        chk("mid_rst_e_out", ifc.E_OUT, 0);
        chk("mid_rst_flags", {ifc.OVF, ifc.UNF}, 0);
        chk("mid_rst_ovf_cnt", ifc.OVF_CNT, 0);
        ifc.out_ready = 1'b1;
        send(3'b001, {6'd3, 6'd4}, 2'b01, {6'd3, 6'd5}, 2'b00, 2'b00);
        drain();
        chk("post_rst_ovf_cnt", ifc.OVF_CNT, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exp_final_stage.md
Name: exp_final_stage

Overview:
- Pipeline stage directly downstream of the exponent pre-calculation block in the multi-format MAF datapath.
- Consumes the pre-computed exponent (12-bit single lane, or two 6-bit lanes in dual mode) and adds the mantissa-rounding carry per lane.
- Detects overflow and underflow per lane, saturates to the infinity or zero code, and forwards the result through a 2-stage elastic valid/ready pipeline.
- Keeps saturating exception event counters for debug and status.

Parameters:
- EMAX1, 2046: max normal biased exponent, mode 1 (12-bit lane).
- EMAX2, 30: max normal biased exponent per 6-bit lane, mode 2.
- EMAX3, 254: max normal biased exponent, mode 3 (12-bit lane).
- CNT_W, 8: width of exception counters.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- CONT  in  3  mode control: CONT[1]=1 is mode 3; else CONT[0]=0 is mode 1; else mode 2. CONT[2] is ignored but passed through.
- E_PRE_C  in  12  pre-computed exponent, two's complement. Mode 2 uses lanes [11:6] (hi) and [5:0] (lo), each 6-bit signed.
- RND_CARRY  in  2  rounding carry. Bit0 is the lo lane, or the single lane in modes 1/3. Bit1 is the hi lane, mode 2 only.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- E_OUT  out  12  final biased exponent (mode 2: two 6-bit fields).
- CONT_OUT  out  3  CONT aligned with E_OUT.
- OVF  out  2  per-lane overflow flag (bit1 is always 0 outside mode 2).
- UNF  out  2  per-lane underflow flag (same lane mapping).
- cnt_clr  in  1  clears both counters.
- OVF_CNT  out  CNT_W  saturating count of accepted output beats with any OVF bit set.
- UNF_CNT  out  CNT_W  same, for any UNF bit set.

Behaviour:
- Reset (rst=1 at clk edge):
  - All valid flags, E_OUT, CONT_OUT, OVF, UNF and both counters become 0.
  - in_ready is 1 in the first cycle after reset.
  - A beat in flight is dropped. Reset overrides in_valid in the same cycle.
- Pipeline structure:
  - S1 registers the inputs.
  - S2 holds the computed result and drives all out_* signals directly from flops.
  - Latency is 2 cycles from input acceptance (in_valid & in_ready) to out_valid.
  - Throughput is 1 beat per cycle with no bubbles.
- Handshake:
  - S2 advances when !s2_valid | out_ready.
  - S1 advances into S2 when s1_valid and S2 advances.
  - in_ready = !s1_valid | (S2 advances). This path is combinational from out_ready.
  - While out_valid=1 and out_ready=0, E_OUT, CONT_OUT, OVF and UNF hold stable.
- Arithmetic, modes 1 and 3:
  - S = sext13(E_PRE_C) + RND_CARRY[0].
  - If S > EMAX, then OVF[0]=1 and E_OUT = EMAX+1. EMAX is EMAX1 in mode 1 and EMAX3 in mode 3.
  - Else if S < 1, then UNF[0]=1 and E_OUT = 0.
  - Else E_OUT = S[11:0].
  - RND_CARRY[1] is ignored.
- Arithmetic, mode 2: each lane independently.
  - S = sext7(lane) + carry.
  - Overflow when S > EMAX2: field = EMAX2+1 (31).
  - Underflow when S < 1: field = 0.
  - No carry propagates between lanes.
- OVF and UNF are never both 1 for the same lane.
- Counters:
  - Increment by 1 on each accepted output beat (out_valid & out_ready) with |OVF (resp. |UNF).
  - Saturate at all-ones, no wrap.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.
- Mode is sampled per beat, so consecutive beats of different modes are legal.

Test Plan:
- Mode 1, E_PRE_C=12'd100, RND_CARRY=0, out_ready=1 -> out_valid 2 cycles after acceptance, E_OUT=100, OVF=UNF=0.
- Mode 1, E_PRE_C=12'd2046, carry=1 -> E_OUT=2047, OVF=01, OVF_CNT=1. Then E_PRE_C=12'hFFF (-1), carry=1 -> E_OUT=0, UNF=01.
- Mode 2, E_PRE_C={6'd30,6'd5}, RND_CARRY=2'b11 -> hi lane overflows (31, OVF[1]=1), lo lane=6. Then E_PRE_C={6'h3E,6'd30}, carry=2'b00 -> hi lane=0 (UNF[1]=1), lo lane=30.
- Mode 3, CONT=3'b010, E_PRE_C=12'd254, carry=1 -> E_OUT=255, OVF=01. Same beat with carry=0 -> E_OUT=254, no flags.
- Backpressure: stream 4 beats with out_ready low for 3 cycles mid-stream -> in_ready drops when both stages are full; no beat lost or duplicated; order preserved; E_OUT stable while stalled.
- Force 300 overflow beats -> OVF_CNT saturates at 255. Assert cnt_clr on the same cycle as an overflow acceptance -> OVF_CNT=0. Reset mid-stream -> out_valid=0 next cycle and counters=0.
